// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and valid/ack handoff to control.
// Optional out-of-range fetch detection is built when ADDR_CHECK_EN is defined.
module fetch_unit #(
  parameter int unsigned          addWidth  = 5,
  parameter int unsigned          dataWidth = 32,
  parameter logic [dataWidth-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_req,
  output logic [dataWidth-1:0] imem_addr,
  input  logic [dataWidth-1:0] imem_data,
  output logic [dataWidth-1:0] ir,
  output logic                 ir_valid,
  input  logic                 ir_ack,
  output logic [dataWidth-1:0] ir_pc,
  output logic [dataWidth-1:0] ir_pc_plus1,
  input  logic                 redirect_valid,
  input  logic [dataWidth-1:0] redirect_target,
  output logic [dataWidth-1:0] pc,
  output logic                 fetch_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [dataWidth-1:0] pc_one = {{(dataWidth-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_next;
  logic [dataWidth-1:0] capture_word;
  logic                 capture_en;

  assign imem_addr   = pc;
  assign ir_valid    = (state == VALID);
  assign ir_pc_plus1 = ir_pc + pc_one;
  // A redirect in the FETCH cycle squashes the capture and the increment.
  assign capture_en  = (state == FETCH) && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (fetch_req) state_next = FETCH;
      FETCH:   state_next = VALID;
      VALID:   if (ir_ack) state_next = fetch_req ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
    if (redirect_valid) state_next = IDLE;
  end

`ifdef ADDR_CHECK_EN
  logic out_of_range;
  logic fault_q;

  assign out_of_range = |pc[dataWidth-1:addWidth];
  assign capture_word = out_of_range ? '0 : imem_data;
  assign fetch_fault  = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (capture_en && out_of_range) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign capture_word = imem_data;
  assign fetch_fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      ir    <= '0;
      ir_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (capture_en) begin
      ir    <= capture_word;
      ir_pc <= pc;
      pc    <= pc + pc_one;
    end
  end

endmodule
